// File: rtl/meduram_2w2r_if.sv
// Request/response bundle for the 2-write / 2-read LVT RAM.
// master: agents drive wr*/rd* requests; slave: RAM returns rddata1/2.
interface meduram_2w2r_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  wren1;
  logic [ADDR_WIDTH-1:0] wraddr1;
  logic [DATA_WIDTH-1:0] wrdata1;
  logic                  wren2;
  logic [ADDR_WIDTH-1:0] wraddr2;
  logic [DATA_WIDTH-1:0] wrdata2;
  logic                  rden1;
  logic [ADDR_WIDTH-1:0] rdaddr1;
  logic [DATA_WIDTH-1:0] rddata1;
  logic                  rden2;
  logic [ADDR_WIDTH-1:0] rdaddr2;
  logic [DATA_WIDTH-1:0] rddata2;

  modport master (
    output wren1, wraddr1, wrdata1,
    output wren2, wraddr2, wrdata2,
    output rden1, rdaddr1,
    output rden2, rdaddr2,
    input  rddata1, rddata2
  );

  modport slave (
    input  wren1, wraddr1, wrdata1,
    input  wren2, wraddr2, wrdata2,
    input  rden1, rdaddr1,
    input  rden2, rdaddr2,
    output rddata1, rddata2
  );
endinterface

// File: rtl/meduram_2w2r.sv
// 2W2R RAM: four 1W1R banks plus a live value table (LVT).
// Ports: aclk, areset (sync, active-high), ram (slave bundle).
// Option: MEDURAM_BYPASS_EN forwards same-edge write data to reads.
module meduram_2w2r #(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic aclk,
  input  logic areset,
  meduram_2w2r_if.slave ram
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  // bank_w_r: written by port w, read by port r
  word_t bank_1_1 [RAM_DEPTH];
  word_t bank_1_2 [RAM_DEPTH];
  word_t bank_2_1 [RAM_DEPTH];
  word_t bank_2_2 [RAM_DEPTH];

  // LVT bit: 0 = port 1 wrote last, 1 = port 2
  logic [RAM_DEPTH-1:0] lvt_q, lvt_d;
  word_t rd1_q, rd1_d;
  word_t rd2_q, rd2_d;

  logic we1, we2;

  assign we1 = ram.wren1 & ~areset;
  assign we2 = ram.wren2 & ~areset;

  always_ff @(posedge aclk) begin
    if (we1) begin
      bank_1_1[ram.wraddr1] <= ram.wrdata1;
      bank_1_2[ram.wraddr1] <= ram.wrdata1;
    end
    if (we2) begin
      bank_2_1[ram.wraddr2] <= ram.wrdata2;
      bank_2_2[ram.wraddr2] <= ram.wrdata2;
    end
  end

  // port 2 is applied last so it wins a same-address collision
  always_comb begin
    lvt_d = lvt_q;
    if (ram.wren1) lvt_d[ram.wraddr1] = 1'b0;
    if (ram.wren2) lvt_d[ram.wraddr2] = 1'b1;
  end

  always_comb begin
    rd1_d = rd1_q;
    if (ram.rden1) begin
      rd1_d = lvt_q[ram.rdaddr1] ? bank_2_1[ram.rdaddr1]
                                 : bank_1_1[ram.rdaddr1];
`ifdef MEDURAM_BYPASS_EN
      if (ram.wren2 && ram.wraddr2 == ram.rdaddr1)
        rd1_d = ram.wrdata2;
      else if (ram.wren1 && ram.wraddr1 == ram.rdaddr1)
        rd1_d = ram.wrdata1;
`endif
    end
  end

  always_comb begin
    rd2_d = rd2_q;
    if (ram.rden2) begin
      rd2_d = lvt_q[ram.rdaddr2] ? bank_2_2[ram.rdaddr2]
                                 : bank_1_2[ram.rdaddr2];
`ifdef MEDURAM_BYPASS_EN
      if (ram.wren2 && ram.wraddr2 == ram.rdaddr2)
        rd2_d = ram.wrdata2;
      else if (ram.wren1 && ram.wraddr1 == ram.rdaddr2)
        rd2_d = ram.wrdata1;
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      lvt_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      lvt_q <= lvt_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign ram.rddata1 = rd1_q;
  assign ram.rddata2 = rd2_q;

endmodule

// File: tb/tb_meduram_2w2r.sv
// Directed + small randomised bench for meduram_2w2r.
// Checks with immediate assertions; prints one summary line.
module tb_meduram_2w2r;

  logic aclk = 1'b0;
  logic areset;
  int   n_chk  = 0;
  int   n_fail = 0;

  meduram_2w2r_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  meduram_2w2r #(
    .ADDR_WIDTH(8),
    .RAM_DEPTH(256),
    .DATA_WIDTH(32)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .ram   (bus.slave)
  );

  always #5 aclk = ~aclk;

  logic [31:0] model [256];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    bus.wren1 = 0; bus.wraddr1 = '0; bus.wrdata1 = '0;
    bus.wren2 = 0; bus.wraddr2 = '0; bus.wrdata2 = '0;
    bus.rden1 = 0; bus.rdaddr1 = '0;
    bus.rden2 = 0; bus.rdaddr2 = '0;
  endtask

  initial begin
    logic [7:0]  a1, a2, r1, r2;
    logic [31:0] d1, d2, x1, x2;
    bit          w1, w2, e1, e2;

    idle();
    areset = 1;
    tick();
    tick();
    chk("reset_rd1", bus.rddata1, 32'h0);
    chk("reset_rd2", bus.rddata2, 32'h0);
    areset = 0;

    // single write, then both ports read it
    bus.wren1 = 1; bus.wraddr1 = 8'h10;
    bus.wrdata1 = 32'hDEADBEEF;
    tick();
    idle();
    bus.rden1 = 1; bus.rdaddr1 = 8'h10;
    bus.rden2 = 1; bus.rdaddr2 = 8'h10;
    tick();
    chk("wr1_rd1", bus.rddata1, 32'hDEADBEEF);
    chk("wr1_rd2", bus.rddata2, 32'hDEADBEEF);

    // concurrent writes to different addresses
    idle();
    bus.wren1 = 1; bus.wraddr1 = 8'h05;
    bus.wrdata1 = 32'h11111111;
    bus.wren2 = 1; bus.wraddr2 = 8'hA0;
    bus.wrdata2 = 32'h22222222;
    tick();
    idle();
    bus.rden1 = 1; bus.rdaddr1 = 8'hA0;
    bus.rden2 = 1; bus.rdaddr2 = 8'h05;
    tick();
    chk("cross_rd1", bus.rddata1, 32'h22222222);
    chk("cross_rd2", bus.rddata2, 32'h11111111);

    // same-address collision: port 2 wins
    idle();
    bus.wren1 = 1; bus.wraddr1 = 8'h33;
    bus.wrdata1 = 32'hAAAA0000;
    bus.wren2 = 1; bus.wraddr2 = 8'h33;
    bus.wrdata2 = 32'h0000BBBB;
    tick();
    idle();
    bus.rden1 = 1; bus.rdaddr1 = 8'h33;
    bus.rden2 = 1; bus.rdaddr2 = 8'h33;
    tick();
    chk("coll_rd1", bus.rddata1, 32'h0000BBBB);
    chk("coll_rd2", bus.rddata2, 32'h0000BBBB);

    // LVT follows the last writer
    idle();
    bus.wren2 = 1; bus.wraddr2 = 8'h7F; bus.wrdata2 = 32'h1;
    tick();
    idle();
    bus.wren1 = 1; bus.wraddr1 = 8'h7F; bus.wrdata1 = 32'h2;
    tick();
    idle();
    bus.rden1 = 1; bus.rdaddr1 = 8'h7F;
    bus.rden2 = 1; bus.rdaddr2 = 8'h7F;
    tick();
    chk("lvt_rd1", bus.rddata1, 32'h2);
    chk("lvt_rd2", bus.rddata2, 32'h2);

    // read and write same address at same edge
    idle();
    bus.wren1 = 1; bus.wraddr1 = 8'h40; bus.wrdata1 = 32'h5;
    tick();
    idle();
    bus.wren1 = 1; bus.wraddr1 = 8'h40; bus.wrdata1 = 32'h6;
    bus.rden1 = 1; bus.rdaddr1 = 8'h40;
    tick();
`ifdef MEDURAM_BYPASS_EN
    chk("rw_same_edge", bus.rddata1, 32'h6);
`else
    chk("rw_same_edge", bus.rddata1, 32'h5);
`endif
    idle();
    bus.rden1 = 1; bus.rdaddr1 = 8'h40;
    tick();
    chk("rw_next_read", bus.rddata1, 32'h6);

    // outputs hold while rden is low
    idle();
    bus.rdaddr1 = 8'h10; bus.rdaddr2 = 8'h05;
    tick();
    tick();
    chk("hold_rd1", bus.rddata1, 32'h6);
    chk("hold_rd2", bus.rddata2, 32'h2);

    // prefill 0xC0..0xC7 from both ports
    for (int k = 0; k < 4; k++) begin
      idle();
      bus.wren1 = 1; bus.wraddr1 = 8'hC0 + 8'(2*k);
      bus.wrdata1 = 32'hC100 + 32'(k);
      bus.wren2 = 1; bus.wraddr2 = 8'hC1 + 8'(2*k);
      bus.wrdata2 = 32'hC200 + 32'(k);
      model[8'hC0 + 8'(2*k)] = 32'hC100 + 32'(k);
      model[8'hC1 + 8'(2*k)] = 32'hC200 + 32'(k);
      tick();
    end

    // randomised concurrent traffic against the model
    x1 = 32'h6;
    x2 = 32'h2;
    for (int i = 0; i < 16; i++) begin
      w1 = 1'($urandom_range(0, 1));
      w2 = 1'($urandom_range(0, 1));
      e1 = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      e2 = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a1 = 8'hC0 + 8'($urandom_range(0, 7));
      a2 = 8'hC0 + 8'($urandom_range(0, 7));
      r1 = 8'hC0 + 8'($urandom_range(0, 7));
      r2 = 8'hC0 + 8'($urandom_range(0, 7));
      d1 = $urandom;
      d2 = $urandom;
      bus.wren1 = w1; bus.wraddr1 = a1; bus.wrdata1 = d1;
      bus.wren2 = w2; bus.wraddr2 = a2; bus.wrdata2 = d2;
      bus.rden1 = e1; bus.rdaddr1 = r1;
      bus.rden2 = e2; bus.rdaddr2 = r2;
      if (e1) begin
        x1 = model[r1];
`ifdef MEDURAM_BYPASS_EN
        if (w2 && a2 == r1) x1 = d2;
        else if (w1 && a1 == r1) x1 = d1;
`endif
      end
      if (e2) begin
        x2 = model[r2];
`ifdef MEDURAM_BYPASS_EN
        if (w2 && a2 == r2) x2 = d2;
        else if (w1 && a1 == r2) x2 = d1;
`endif
      end
      if (w1) model[a1] = d1;
      if (w2) model[a2] = d2;
      tick();
      chk($sformatf("rand%0d_rd1", i), bus.rddata1, x1);
      chk($sformatf("rand%0d_rd2", i), bus.rddata2, x2);
    end

    // reset mid-operation with reads and a write pending
    idle();
    areset = 1;
    bus.rden1 = 1; bus.rdaddr1 = 8'hC0;
    bus.rden2 = 1; bus.rdaddr2 = 8'hC1;
    bus.wren1 = 1; bus.wraddr1 = 8'h10; bus.wrdata1 = 32'h99;
    tick();
    chk("midrst_rd1", bus.rddata1, 32'h0);
    chk("midrst_rd2", bus.rddata2, 32'h0);

    // write during reset was dropped; rd2 idle holds 0
    areset = 0;
    idle();
    bus.rden1 = 1; bus.rdaddr1 = 8'h10;
    bus.rdaddr2 = 8'h10;
    tick();
    chk("post_rst_rd1", bus.rddata1, 32'hDEADBEEF);
    chk("post_rst_hold2", bus.rddata2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
